// File: rtl/lsu_dmio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared encodings for the load/store unit (sizes, FSM states, IO select)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam int IO_SEL_BIT = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // An access is aligned when the offset is a multiple of its size in bytes.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = off[0];
            SZ_WORD: r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmio_ctrl_if
// Brief    : Request/response handshake and doubleword memory/IO bus of the LSU
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_dmio_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    logic [12:0] mem_dir;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;

    // Environment side: processor requests plus the memory/IO read data.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_dir, mem_wdata, mem_wr
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_dir, mem_wdata, mem_wr
    );

endinterface
`default_nettype wire

// File: rtl/lsu_dmio_ctrl_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Byte-lane merge for sub-dword stores and extract/extend for loads
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  wire logic [63:0] i_data,
    input  wire logic [63:0] i_wdata,
    input  wire logic [2:0]  i_off,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_sgn,
    output logic      [63:0] o_merged,
    output logic      [63:0] o_extracted
);

    logic [63:0] w_fmask;
    logic [63:0] w_lmask;
    logic [63:0] w_field;
    logic [5:0]  w_shamt;

    always_comb begin
        w_shamt = {i_off, 3'b000};
        case (i_size)
            SZ_BYTE: w_fmask = 64'h0000_0000_0000_00FF;
            SZ_HALF: w_fmask = 64'h0000_0000_0000_FFFF;
            SZ_WORD: w_fmask = 64'h0000_0000_FFFF_FFFF;
            default: w_fmask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        w_lmask  = w_fmask << w_shamt;
        o_merged = (i_data & ~w_lmask) | ((i_wdata & w_fmask) << w_shamt);

        w_field = i_data >> w_shamt;
        case (i_size)
            SZ_BYTE: o_extracted = {{56{i_sgn & w_field[7]}},  w_field[7:0]};
            SZ_HALF: o_extracted = {{48{i_sgn & w_field[15]}}, w_field[15:0]};
            SZ_WORD: o_extracted = {{32{i_sgn & w_field[31]}}, w_field[31:0]};
            default: o_extracted = w_field;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_dmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmio_ctrl
// Brief    : Load/store unit turning sized accesses into doubleword RAM/IO cycles
// Revision : 1.0 - initial release
// ============================================================================
module lsu_dmio_ctrl
    import lsu_pkg::*;
#(
    parameter int READ_LAT = 1
)(
    input  wire logic  clk,
    input  wire logic  rst,
    lsu_dmio_ctrl_if.slave bus
);

    localparam int              c_CW  = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam logic [c_CW-1:0] c_LAT = c_CW'(READ_LAT);

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [63:0]     r_rsp_rdata;
    logic            r_rsp_err;
    logic [12:0]     r_dir;
    logic [63:0]     r_mem_wdata;
    logic            r_wr;

    logic            r_we;
    logic [1:0]      r_size;
    logic            r_sgn;
    logic [2:0]      r_off;
    logic [63:0]     r_wdata;

    logic [63:0]     w_merged;
    logic [63:0]     w_extracted;
    logic            w_misal;
    logic            w_io_req;

    assign w_misal  = is_misaligned(bus.req_size, bus.req_addr[2:0]);
    assign w_io_req = bus.req_addr[15];

    lsu_lane_align u_align (
        .i_data      (bus.mem_rdata),
        .i_wdata     (r_wdata),
        .i_off       (r_off),
        .i_size      (r_size),
        .i_sgn       (r_sgn),
        .o_merged    (w_merged),
        .o_extracted (w_extracted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_dir       <= '0;
            r_mem_wdata <= '0;
            r_wr        <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_sgn       <= 1'b0;
            r_off       <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_we        <= bus.req_we;
                        r_size      <= bus.req_size;
                        r_sgn       <= bus.req_signed;
                        r_off       <= bus.req_addr[2:0];
                        r_wdata     <= bus.req_wdata;
                        r_dir       <= bus.req_addr[15:3];
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b0;
                        if (w_misal) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (bus.req_we && w_io_req) begin
                            // IO registers are byte-wide regardless of access size.
                            r_mem_wdata <= {56'b0, bus.req_wdata[7:0]};
                            r_wr        <= 1'b1;
                            r_state     <= ST_WRITE;
                        end else if (bus.req_we && bus.req_size == SZ_DWORD) begin
                            r_mem_wdata <= bus.req_wdata;
                            r_wr        <= 1'b1;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_cnt == c_LAT) begin
                        if (r_we) begin
                            r_mem_wdata <= w_merged;
                            r_wr        <= 1'b1;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_rsp_rdata <= r_dir[IO_SEL_BIT] ? bus.mem_rdata : w_extracted;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                ST_WRITE: begin
                    r_wr        <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                default: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_dir   = r_dir;
    assign bus.mem_wdata = r_mem_wdata;
    // Reset suppresses a write strobe in the very cycle it is raised.
    assign bus.mem_wr    = r_wr & ~rst;

endmodule
`default_nettype wire
